seq_restoring_div: RTL

SEQ_RESTORING_DIV -- requirements
Module: seq_restoring_div

---
 rtl/div_pkg.sv | 11 +
 rtl/div_trial_sub.sv | 26 ++
 rtl/seq_restoring_div.sv | 133 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the controller state encoding used by the top-level FSM.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_trial_sub.sv
// Combinational W-bit trial subtractor for one restoring division step.
// Ripple-borrow chain; borrow high means minuend < subtrahend.
module div_trial_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] minuend,
    input  logic [W-1:0] subtrahend,
    output logic [W-1:0] difference,
    output logic         borrow
);

    logic [W:0] borrow_chain;

    assign borrow_chain[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign difference[gi]     = minuend[gi] ^ subtrahend[gi] ^ borrow_chain[gi];
            assign borrow_chain[gi+1] = (~minuend[gi] & subtrahend[gi])
                                      | (~(minuend[gi] ^ subtrahend[gi]) & borrow_chain[gi]);
        end
    endgenerate

    assign borrow = borrow_chain[W];

endmodule

// File: rtl/seq_restoring_div.sv
// Sequential unsigned restoring divider: one quotient bit per RUN cycle,
// results registered and held from done until the next accepted start.
import div_pkg::*;

module seq_restoring_div #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    div_state_e  state_q, state_d;
    logic [N:0]    p_q, p_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rem_q, rem_d;
    logic          dbz_q, dbz_d;

    logic [N:0]    p_shift;
    logic [N:0]    trial_diff;
    logic          trial_borrow;
    logic [N:0]    step_p;
    logic [N-1:0]  step_q;

    // The restored remainder is always below the divisor, so its MSB never
    // feeds the next shift; it exists only to hold a full-width trial result.
    logic unused_p_msb;
    assign unused_p_msb = p_q[N];

    assign p_shift = {p_q[N-1:0], q_q[N-1]};

    div_trial_sub #(
        .W (N + 1)
    ) u_trial_sub (
        .minuend    (p_shift),
        .subtrahend ({1'b0, d_q}),
        .difference (trial_diff),
        .borrow     (trial_borrow)
    );

    assign step_p = trial_borrow ? p_shift : trial_diff;
    assign step_q = {q_q[N-2:0], ~trial_borrow};

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    p_d   = '0;
                    q_d   = dividend;
                    d_d   = divisor;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                p_d   = step_p;
                q_d   = step_q;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = DONE;
                    quo_d   = step_q;
                    rem_d   = step_p[N-1:0];
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // Outputs are forced low for the whole time rst is high, not just after the edge.
    assign busy        = ~rst & (state_q != IDLE);
    assign done        = ~rst & (state_q == DONE);
    assign quotient    = rst ? '0 : quo_q;
    assign remainder   = rst ? '0 : rem_q;
    assign div_by_zero = ~rst & dbz_q;

endmodule
